uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, line FSM state encoding and bit-timing helpers.
// Also intended for the receiver side.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Rounded division so the bit period is as close as possible to the nominal baud.
    function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
        return (clk_freq_hz + baud_rate / 2) / baud_rate;
    endfunction

    function automatic logic parity_bit(input logic [8:0] data, input int unsigned nbits,
                                        input int mode);
        logic ones;
        ones = 1'b0;
        for (int unsigned i = 0; i < nbits; i++) begin
            ones ^= data[i];
        end
        return (mode == PAR_ODD) ? ~ones : ones;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] LEVEL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level disambiguates full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: frames queued payloads back-to-back onto serial_tx.
// Frame = start, DATA_BITS LSB first, optional parity, STOP stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 33330000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP        = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_byte,
    input  logic                          send_byte,
    output logic                          tx_ready,
    output logic                          serial_tx,
    output logic                          byte_sent,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP - 1);

    uart_state_e          state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 next_par;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (send_byte),
        .din   (tx_byte),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign tx_ready = !fifo_full;

    always_comb begin
        bit_end   = (baud_cnt == BIT_LAST);
        last_data = (bit_cnt == DATA_LAST);
        last_stop = (bit_cnt == STOP_LAST);
        next_par  = parity_bit(9'(fifo_dout), DATA_BITS, PARITY);
        pop       = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE) begin
                pop = 1'b1;
            end else if (state == ST_STOP && bit_end && last_stop) begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            serial_tx <= 1'b1;
            busy      <= 1'b0;
            byte_sent <= 1'b0;
        end else begin
            // Line outputs are registered from the current state, so they trail the
            // FSM by one cycle; every bit still lasts exactly CPB cycles.
            busy      <= (state != ST_IDLE);
            byte_sent <= (state == ST_STOP) && bit_end && last_stop;
            case (state)
                ST_START:  serial_tx <= 1'b0;
                ST_DATA:   serial_tx <= shift_reg[0];
                ST_PARITY: serial_tx <= par_bit;
                default:   serial_tx <= 1'b1;
            endcase

            if (state == ST_IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (pop) begin
                shift_reg <= fifo_dout;
                par_bit   <= next_par;
            end

            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (pop) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (last_data) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            bit_cnt <= '0;
                            state   <= pop ? ST_START : ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/timeline model of an 8N1 instance plus fixed-frame
// checks of 7E2, 8O1 and default-parameter instances.
module tb_uart_tx_fifo;

    localparam int CPB   = 10;
    localparam int FL    = 10 * CPB;
    localparam int DEPTH = 4;

    logic clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;
    logic rst_n = 1'b0;

    logic [7:0] a_byte;
    logic       a_send, a_ready, a_ser, a_sent, a_busy;
    logic [2:0] a_level;
    logic [6:0] b_byte;
    logic       b_send, b_ready, b_ser, b_sent, b_busy;
    logic [2:0] b_level;
    logic [7:0] c_byte;
    logic       c_send, c_ready, c_ser, c_sent, c_busy;
    logic [2:0] c_level;
    logic [7:0] d_byte;
    logic       d_send, d_ready, d_ser, d_sent, d_busy;
    logic [2:0] d_level;

    uart_tx_fifo #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(0), .STOP(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk_tb), .rst_n(rst_n), .tx_byte(a_byte), .send_byte(a_send),
        .tx_ready(a_ready), .serial_tx(a_ser), .byte_sent(a_sent), .busy(a_busy),
        .fifo_level(a_level));

    uart_tx_fifo #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                   .PARITY(2), .STOP(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk_tb), .rst_n(rst_n), .tx_byte(b_byte), .send_byte(b_send),
        .tx_ready(b_ready), .serial_tx(b_ser), .byte_sent(b_sent), .busy(b_busy),
        .fifo_level(b_level));

    uart_tx_fifo #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(1), .STOP(1), .FIFO_DEPTH(4)) dut_c (
        .clk(clk_tb), .rst_n(rst_n), .tx_byte(c_byte), .send_byte(c_send),
        .tx_ready(c_ready), .serial_tx(c_ser), .byte_sent(c_sent), .busy(c_busy),
        .fifo_level(c_level));

    uart_tx_fifo dut_d (
        .clk(clk_tb), .rst_n(rst_n), .tx_byte(d_byte), .send_byte(d_send),
        .tx_ready(d_ready), .serial_tx(d_ser), .byte_sent(d_sent), .busy(d_busy),
        .fifo_level(d_level));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference for dut_a: queued payloads plus position within the frame on the line.
    logic [7:0] mq[$];
    int         m_pos = -1;
    logic [7:0] m_cur = '0;
    logic [7:0] m_pend_byte = '0;
    logic       m_pend = 1'b0;
    logic       cmp_en = 1'b0;

    always @(posedge clk_tb or negedge rst_n) begin : model
        int pre_size;
        if (!rst_n) begin
            mq.delete();
            m_pos  = -1;
            m_pend = 1'b0;
        end else begin
            pre_size = mq.size();
            if (m_pos >= 0 && m_pos < FL - 1) begin
                m_pos++;
            end else if (m_pend) begin
                m_pos  = 0;
                m_cur  = m_pend_byte;
                m_pend = 1'b0;
            end else begin
                m_pos = -1;
            end
            if (pre_size > 0 && (m_pos == FL - 1 || m_pos == -1)) begin
                m_pend_byte = mq.pop_front();
                m_pend      = 1'b1;
            end
            if (a_send && pre_size < DEPTH) begin
                mq.push_back(a_byte);
            end
        end
    end

    function automatic logic exp_line(input int pos, input logic [7:0] b);
        int slot;
        if (pos < 0) return 1'b1;
        slot = pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    always @(negedge clk_tb) begin
        if (cmp_en) begin
            check("serial_tx", a_ser, exp_line(m_pos, m_cur));
            check("busy", a_busy, m_pos >= 0);
            check("byte_sent", a_sent, m_pos == FL - 1);
            check("tx_ready", a_ready, mq.size() < DEPTH);
            check("fifo_level", a_level, mq.size());
        end
    end

    // Sends one payload to the selected instance and records the line for max_cyc cycles.
    task automatic capture(input int sel, input logic [8:0] data, input int cpb,
                           input int max_cyc, output logic [15:0] slots,
                           output int first_low, output int busy_cnt, output int sent_at,
                           output int sent_cnt, output int low_cnt);
        logic ser, bsy, snt;
        int   s;
        slots = '0; first_low = -1; busy_cnt = 0; sent_at = -1; sent_cnt = 0; low_cnt = 0;
        @(negedge clk_tb);
        case (sel)
            0:       begin a_byte = data[7:0]; a_send = 1'b1; end
            1:       begin b_byte = data[6:0]; b_send = 1'b1; end
            2:       begin c_byte = data[7:0]; c_send = 1'b1; end
            default: begin d_byte = data[7:0]; d_send = 1'b1; end
        endcase
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk_tb);
            case (sel)
                0:       begin ser = a_ser; bsy = a_busy; snt = a_sent; end
                1:       begin ser = b_ser; bsy = b_busy; snt = b_sent; end
                2:       begin ser = c_ser; bsy = c_busy; snt = c_sent; end
                default: begin ser = d_ser; bsy = d_busy; snt = d_sent; end
            endcase
            if (k == 0) begin
                a_send = 1'b0; b_send = 1'b0; c_send = 1'b0; d_send = 1'b0;
            end
            if (!ser) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
            end
            if (bsy) busy_cnt++;
            if (snt) begin
                sent_cnt++;
                sent_at = k;
            end
            if (first_low >= 0 && (k - first_low) % cpb == cpb / 2) begin
                s = (k - first_low) / cpb;
                if (s < 16) slots[s] = ser;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] slots;
        int first_low, busy_cnt, sent_at, sent_cnt, low_cnt;
        int t_prev, n, busy_seen, low_seen, thr;

        a_send = 1'b0; a_byte = '0; b_send = 1'b0; b_byte = '0;
        c_send = 1'b0; c_byte = '0; d_send = 1'b0; d_byte = '0;
        repeat (3) @(negedge clk_tb);
        check("reset serial_tx", a_ser, 1);
        check("reset busy", a_busy, 0);
        check("reset byte_sent", a_sent, 0);
        check("reset tx_ready", a_ready, 1);
        check("reset fifo_level", a_level, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk_tb);

        // 8N1, 0x88: start, 0,0,0,1,0,0,0,1, stop
        capture(0, 9'h088, CPB, 120, slots, first_low, busy_cnt, sent_at, sent_cnt, low_cnt);
        check("8N1 first low cycle", first_low, 2);
        check("8N1 frame bits", slots[9:0], 10'h310);
        check("8N1 busy cycles", busy_cnt, 100);
        check("8N1 byte_sent cycle", sent_at, 101);
        check("8N1 byte_sent count", sent_cnt, 1);

        // 7E2, 0x55: four ones -> parity 0, 11 bits
        capture(1, 9'h055, CPB, 130, slots, first_low, busy_cnt, sent_at, sent_cnt, low_cnt);
        check("7E2 frame bits", slots[10:0], 11'h6AA);
        check("7E2 busy cycles", busy_cnt, 110);
        check("7E2 byte_sent cycle", sent_at, 111);
        check("7E2 tx_ready", b_ready, 1);
        check("7E2 fifo_level", b_level, 0);

        capture(2, 9'h000, CPB, 130, slots, first_low, busy_cnt, sent_at, sent_cnt, low_cnt);
        check("8O1 0x00 frame bits", slots[10:0], 11'h600);
        check("8O1 0x00 parity", slots[9], 1);
        capture(2, 9'h0FF, CPB, 130, slots, first_low, busy_cnt, sent_at, sent_cnt, low_cnt);
        check("8O1 0xFF frame bits", slots[10:0], 11'h7FE);
        check("8O1 0xFF parity", slots[9], 1);
        check("8O1 busy cycles", busy_cnt, 110);
        check("8O1 fifo_level", c_level, 0);
        check("8O1 tx_ready", c_ready, 1);

        // Defaults: 289 clk per bit
        capture(3, 9'h0FF, 289, 2920, slots, first_low, busy_cnt, sent_at, sent_cnt, low_cnt);
        check("default start bit cycles", low_cnt, 289);
        check("default frame cycles", busy_cnt, 2890);
        check("default byte_sent cycle", sent_at, 2891);
        check("default frame bits", slots[9:0], 10'h3FE);
        check("default tx_ready", d_ready, 1);
        check("default fifo_level", d_level, 0);
        check("default byte_sent idle", d_sent, 0);

        // Five pushes on consecutive cycles into a depth-4 queue
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_tb);
            a_send = 1'b1;
            a_byte = 8'hA0 + 8'(i);
        end
        @(negedge clk_tb);
        a_send = 1'b0;
        check("burst tx_ready", a_ready, 0);
        check("burst fifo_level", a_level, 4);
        t_prev = -1;
        n = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk_tb);
            if (a_sent) begin
                if (n > 0) check("burst byte_sent spacing", k - t_prev, 100);
                t_prev = k;
                n++;
            end
        end
        check("burst frame count", n, 5);

        // Reset in the middle of the data bits of 0x00 with three entries queued
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_tb);
            a_send = 1'b1;
            a_byte = (i == 0) ? 8'h00 : 8'h5A;
        end
        @(negedge clk_tb);
        a_send = 1'b0;
        repeat (30) @(negedge clk_tb);
        #2;
        check("pre-reset serial_tx", a_ser, 0);
        check("pre-reset fifo_level", a_level, 3);
        rst_n = 1'b0;
        #1;
        check("async reset serial_tx", a_ser, 1);
        check("async reset busy", a_busy, 0);
        check("async reset byte_sent", a_sent, 0);
        check("async reset fifo_level", a_level, 0);
        check("async reset tx_ready", a_ready, 1);
        repeat (2) @(negedge clk_tb);
        rst_n = 1'b1;
        busy_seen = 0;
        low_seen  = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_tb);
            if (a_busy) busy_seen++;
            if (!a_ser) low_seen++;
        end
        check("post-reset busy cycles", busy_seen, 0);
        check("post-reset low cycles", low_seen, 0);

        // Random traffic at varying offered load, with one reset mid-run
        for (int blk = 0; blk < 8; blk++) begin
            thr = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 30 : 95);
            for (int c = 0; c < 500; c++) begin
                @(negedge clk_tb);
                a_send = ($urandom_range(0, 99) < thr);
                a_byte = 8'($urandom);
                if (blk == 5 && c == 250) begin
                    #2 rst_n = 1'b0;
                    @(negedge clk_tb);
                    #2 rst_n = 1'b1;
                end
            end
        end
        a_send = 1'b0;
        repeat (20) @(negedge clk_tb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
